slot_bcd_seq: RTL

Sequential, parametrised binary-to-BCD converter for the slot display path. It converts NUM_SLOTS unsigned slot values into DIGITS decimal digits each, using a shift-and-add-3 (double dabble) engine that processes one slot at a time. It sits between the slot value registers and the seven-segment digit drivers. It adds a start/busy/done handshake, per-slot overflow flags, and an atomic update of all output digits.

---
 rtl/slot_bcd_seq_if.sv | 17 +
 rtl/slot_bcd_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/slot_bcd_seq_if.sv
// Handshake and data bundle between the slot value registers and the
// sequential binary-to-BCD converter.
interface slot_bcd_seq_if #(
  parameter int NUM_SLOTS = 3,
  parameter int VAL_W     = 4,
  parameter int DIGITS    = 2
);
  logic                          start;
  logic [NUM_SLOTS*VAL_W-1:0]    slots;
  logic                          busy;
  logic                          done;
  logic [NUM_SLOTS*DIGITS*4-1:0] slot_nums;
  logic [NUM_SLOTS-1:0]          overflow;

  modport master (output start, slots, input busy, done, slot_nums, overflow);
  modport slave  (input start, slots, output busy, done, slot_nums, overflow);
endinterface

// File: rtl/slot_bcd_seq.sv
// Sequential double-dabble converter: one slot at a time through a shared
// shift-and-add-3 engine; all digit outputs update together when DONE is entered.
module slot_bcd_seq #(
  parameter int NUM_SLOTS = 3,
  parameter int VAL_W     = 4,
  parameter int DIGITS    = 2
) (
  input  logic            clk,
  input  logic            reset,
  slot_bcd_seq_if.slave   bus
);
  // Enough internal digits to hold any VAL_W-bit value, so overflow is exact.
  localparam int INT_DIGITS = (DIGITS > (VAL_W + 2) / 3) ? DIGITS : (VAL_W + 2) / 3;
  localparam int SR_W       = INT_DIGITS * 4 + VAL_W;
  localparam int IDX_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W      = $clog2(VAL_W + 1);
  localparam int NUMS_W     = NUM_SLOTS * DIGITS * 4;
  localparam int SLOTS_W    = NUM_SLOTS * VAL_W;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [SLOTS_W-1:0]   shadow_reg, shadow_next;
  logic [SR_W-1:0]      sr_reg, sr_next;
  logic [SR_W-1:0]      adj;
  logic [NUMS_W-1:0]    stage_nums_reg, stage_nums_next;
  logic [NUM_SLOTS-1:0] stage_ovf_reg, stage_ovf_next;
  logic [NUMS_W-1:0]    nums_reg, nums_next;
  logic [NUM_SLOTS-1:0] ovf_reg, ovf_next;
  logic                 ovf_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      shadow_reg     <= '0;
      sr_reg         <= '0;
      stage_nums_reg <= '0;
      stage_ovf_reg  <= '0;
      nums_reg       <= '0;
      ovf_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      shadow_reg     <= shadow_next;
      sr_reg         <= sr_next;
      stage_nums_reg <= stage_nums_next;
      stage_ovf_reg  <= stage_ovf_next;
      nums_reg       <= nums_next;
      ovf_reg        <= ovf_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cnt_next        = cnt_reg;
    shadow_next     = shadow_reg;
    sr_next         = sr_reg;
    stage_nums_next = stage_nums_reg;
    stage_ovf_next  = stage_ovf_reg;
    nums_next       = nums_reg;
    ovf_next        = ovf_reg;
    ovf_bit         = 1'b0;

    // Add-3 correction on every BCD nibble; the 4-bit wrap is safe since a
    // nibble >= 5 never exceeds 9 before the add.
    adj = sr_reg;
    for (int d = 0; d < INT_DIGITS; d++) begin
      if (sr_reg[VAL_W + 4*d +: 4] >= 4'd5)
        adj[VAL_W + 4*d +: 4] = sr_reg[VAL_W + 4*d +: 4] + 4'd3;
    end

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          shadow_next = bus.slots;
          idx_next    = '0;
          state_next  = LOAD;
        end
      end
      LOAD: begin
        sr_next    = SR_W'(shadow_reg[int'(idx_reg)*VAL_W +: VAL_W]);
        cnt_next   = '0;
        state_next = SHIFT;
      end
      SHIFT: begin
        sr_next  = {adj[SR_W-2:0], 1'b0};
        cnt_next = cnt_reg + CNT_W'(1);
        if (int'(cnt_reg) == VAL_W - 1)
          state_next = STORE;
      end
      STORE: begin
        // Digit j=0 is the most significant of the kept digits.
        for (int j = 0; j < DIGITS; j++)
          stage_nums_next[(int'(idx_reg)*DIGITS + j)*4 +: 4] =
            sr_reg[VAL_W + (DIGITS-1-j)*4 +: 4];
        for (int d = DIGITS; d < INT_DIGITS; d++)
          ovf_bit = ovf_bit | (|sr_reg[VAL_W + 4*d +: 4]);
        stage_ovf_next[idx_reg] = ovf_bit;
        if (int'(idx_reg) == NUM_SLOTS - 1) begin
          nums_next  = stage_nums_next;
          ovf_next   = stage_ovf_next;
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + IDX_W'(1);
          state_next = LOAD;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.slot_nums = nums_reg;
  assign bus.overflow  = ovf_reg;
endmodule
